// File: rtl/sqrt_bcd.sv
// Converts a captured 16-bit square-root result into five BCD digits using
// a serial double-dabble (16 steps), with optional leading-zero blanking.
module sqrt_bcd #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_result,
  input  logic        in_cflag,
  input  logic        in_oflag,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd,
  output logic        cflag_out,
  output logic        err_out,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t      state;
  logic        in_valid_d;
  logic [3:0]  shift_cnt;
  logic [19:0] dig_work;
  logic [15:0] bin_work;
  logic        cflag_lat;
  logic        err_lat;
  logic        capture;
  logic [19:0] dig_adj;

  function automatic logic [19:0] dabble_adjust(input logic [19:0] d);
    logic [19:0] r;
    r = d;
    for (int i = 0; i < 5; i++) begin
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Digit 0 is never blanked, so a zero result still shows a single 0.
  function automatic logic [19:0] blank_leading(input logic [19:0] d);
    logic [19:0] r;
    logic        lead;
    r    = d;
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (lead && (d[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
    return r;
  endfunction

  assign capture = in_valid & ~in_valid_d;
  assign dig_adj = dabble_adjust(dig_work);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_valid_d <= 1'b0;
      shift_cnt  <= 4'd0;
      dig_work   <= 20'h00000;
      bin_work   <= 16'h0000;
      cflag_lat  <= 1'b0;
      err_lat    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= 20'h00000;
      cflag_out  <= 1'b0;
      err_out    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      in_valid_d <= in_valid;
      done       <= 1'b0;
      // Any rising edge seen outside IDLE (including the FINISH edge) is dropped.
      if (capture && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (capture) begin
            bin_work  <= in_result;
            dig_work  <= 20'h00000;
            cflag_lat <= in_cflag;
            err_lat   <= in_oflag;
            shift_cnt <= 4'd0;
            overrun   <= 1'b0;
            busy      <= 1'b1;
            state     <= in_oflag ? FINISH : SHIFT;
          end
        end
        SHIFT: begin
          dig_work  <= {dig_adj[18:0], bin_work[15]};
          bin_work  <= {bin_work[14:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == 4'd15) state <= FINISH;
        end
        FINISH: begin
          if (err_lat)            bcd <= 20'hEEEEE;
          else if (BLANK_LEADING) bcd <= blank_leading(dig_work);
          else                    bcd <= dig_work;
          cflag_out <= cflag_lat;
          err_out   <= err_lat;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_bcd.sv
// Bench for sqrt_bcd: a cycle-level arithmetic model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_sqrt_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_result = 16'h0000;
  logic        in_cflag = 1'b0;
  logic        in_oflag = 1'b0;

  logic        busy, done, cflag_out, err_out, overrun;
  logic [19:0] bcd;
  logic        busy_r, done_r, cflag_r, err_r, overrun_r;
  logic [19:0] bcd_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sqrt_bcd #(.BLANK_LEADING(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result),
    .in_cflag(in_cflag), .in_oflag(in_oflag), .busy(busy), .done(done),
    .bcd(bcd), .cflag_out(cflag_out), .err_out(err_out), .overrun(overrun)
  );

  sqrt_bcd #(.BLANK_LEADING(1'b0)) u_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result),
    .in_cflag(in_cflag), .in_oflag(in_oflag), .busy(busy_r), .done(done_r),
    .bcd(bcd_r), .cflag_out(cflag_r), .err_out(err_r), .overrun(overrun_r)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by division; digits above the value's decimal length blank.
  function automatic logic [19:0] exp_bcd(input int v, input bit err, input bit blank);
    logic [19:0] r;
    int t, nd;
    if (err) return 20'hEEEEE;
    nd = (v >= 10000) ? 5 : (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = (blank && i >= nd) ? 4'hF : 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Model: a countdown of edges left until done; zero means idle.
  bit          m_vd = 1'b0;
  int          m_left = 0;
  int          m_val = 0;
  bit          m_cf = 1'b0, m_er = 1'b0;
  bit          m_busy = 1'b0, m_done = 1'b0, m_cfo = 1'b0, m_ero = 1'b0, m_ovr = 1'b0;
  logic [19:0] m_bcd = 20'h0, m_bcd_r = 20'h0;
  wire         m_cap = in_valid && !m_vd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_vd <= 1'b0; m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_cfo <= 1'b0; m_ero <= 1'b0; m_ovr <= 1'b0;
      m_bcd <= 20'h0; m_bcd_r <= 20'h0;
    end else begin
      m_vd   <= in_valid;
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (m_cap) m_ovr <= 1'b1;
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done  <= 1'b1;
          m_busy  <= 1'b0;
          m_bcd   <= exp_bcd(m_val, m_er, 1'b1);
          m_bcd_r <= exp_bcd(m_val, m_er, 1'b0);
          m_cfo   <= m_cf;
          m_ero   <= m_er;
        end
      end else if (m_cap) begin
        m_val  <= int'(in_result);
        m_cf   <= in_cflag;
        m_er   <= in_oflag;
        m_ovr  <= 1'b0;
        m_busy <= 1'b1;
        m_left <= in_oflag ? 1 : 17;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("bcd", bcd, m_bcd);
    check("cflag_out", cflag_out, m_cfo);
    check("err_out", err_out, m_ero);
    check("overrun", overrun, m_ovr);
    check("raw_busy", busy_r, m_busy);
    check("raw_done", done_r, m_done);
    check("raw_bcd", bcd_r, m_bcd_r);
    check("raw_cflag", cflag_r, m_cfo);
    check("raw_err", err_r, m_ero);
    check("raw_overrun", overrun_r, m_ovr);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edge index of done, counting the next rising edge as 1.
  task automatic wait_done(input int max, output int k);
    k = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) in_result = 16'($urandom);
      if (done) begin
        k = i;
        break;
      end
    end
    if (k == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic convert(input logic [15:0] v, input bit cf, input bit of,
                         input logic [19:0] exp, input int lat);
    int k;
    in_result = v;
    in_cflag  = cf;
    in_oflag  = of;
    in_valid  = 1'b1;
    wait_done(40, k);
    check("latency", k - 1, lat);
    check("bcd_lit", bcd, exp);
    check("cflag_lit", cflag_out, cf);
    check("err_lit", err_out, of);
    if (k < 30) tick(30 - k);
    in_valid = 1'b0;
    in_oflag = 1'b0;
    in_cflag = 1'b0;
    tick(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_bcd", bcd, 20'h00000);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    tick(2);

    convert(16'd8, 1'b0, 1'b0, 20'hFFFF8, 17);
    check("raw_bcd_8", bcd_r, 20'h00008);
    check("busy_after", busy, 0);
    convert(16'd65535, 1'b0, 1'b0, 20'h65535, 17);
    convert(16'd0, 1'b0, 1'b0, 20'hFFFF0, 17);
    check("raw_bcd_0", bcd_r, 20'h00000);
    convert(16'd1000, 1'b1, 1'b0, 20'hF1000, 17);
    convert(16'd1234, 1'b0, 1'b1, 20'hEEEEE, 1);
    check("raw_bcd_err", bcd_r, 20'hEEEEE);

    // Second rising edge five cycles into a conversion.
    in_result = 16'd42;
    in_valid  = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(4);
    in_valid = 1'b1;
    wait_done(40, k);
    check("ovr_bcd", bcd, 20'hFFF42);
    check("ovr_set", overrun, 1);
    in_valid = 1'b0;
    tick(2);
    convert(16'd7, 1'b0, 1'b0, 20'hFFFF7, 17);
    check("ovr_clear", overrun, 0);

    // Rising edge coincides with the FINISH edge.
    in_result = 16'd300;
    in_valid  = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(16);
    in_valid = 1'b1;
    tick(1);
    check("fin_done", done, 1);
    check("fin_bcd", bcd, 20'hFF300);
    check("fin_ovr", overrun, 1);
    tick(5);
    check("fin_no_restart", busy, 0);
    in_valid = 1'b0;
    tick(2);

    // Asynchronous reset in the middle of a conversion.
    in_result = 16'd99;
    in_valid  = 1'b1;
    tick(8);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_bcd", bcd, 20'h00000);
    check("arst_ovr", overrun, 0);
    check("arst_err", err_out, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    wait_done(40, k);
    check("arst_latency", k - 1, 17);
    check("arst_conv", bcd, 20'hFFF99);
    in_valid = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
